keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, per-key debounce and a FWFT event FIFO.
// Define KEYPAD_RELEASE_EVENT_EN to also queue release events ({1'b1,k}).
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        enable,
  output logic [3:0]  keypad_col,
  input  logic [3:0]  keypad_row,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [4:0]  key_code,
  output logic [15:0] key_pressed,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic        irq
);

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, COMMIT} state_t;

  // Reset asserts asynchronously, deasserts two edges after axi_aresetn rises
  logic [1:0] rst_q;
  logic       rst_n;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) rst_q <= '0;
    else              rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  logic [3:0] row_meta_q, row_sync_q;

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= keypad_row;
      row_sync_q <= row_meta_q;
    end
  end

  state_t               state_q, state_d;
  logic [1:0]           col_idx_q, col_idx_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           key_idx_q, key_idx_d;
  logic [3:0]           col_drive_c;
  logic                 sample_c, commit_c;

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_idx_q  <= '0;
      timer_q    <= '0;
      key_idx_q  <= '0;
      keypad_col <= 4'hF;
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      timer_q    <= timer_d;
      key_idx_q  <= key_idx_d;
      keypad_col <= col_drive_c;
    end
  end

  // Dropping enable abandons the partial scan; debounce state and FIFO are kept
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    timer_d     = timer_q;
    key_idx_d   = key_idx_q;
    sample_c    = 1'b0;
    commit_c    = 1'b0;
    col_drive_c = 4'hF;
    if (!enable) begin
      state_d   = IDLE;
      col_idx_d = '0;
      timer_d   = '0;
      key_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = DRIVE;
          col_idx_d = '0;
          timer_d   = '0;
        end
        DRIVE: begin
          if (timer_q == TIMER_W'(SETTLE_CYCLES - 1)) begin
            state_d = SAMPLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        SAMPLE: begin
          sample_c = 1'b1;
          if (col_idx_q == 2'd3) begin
            state_d   = COMMIT;
            key_idx_d = '0;
          end else begin
            state_d   = DRIVE;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        COMMIT: begin
          commit_c  = 1'b1;
          key_idx_d = key_idx_q + 4'd1;
          if (key_idx_q == 4'd15) begin
            state_d   = DRIVE;
            col_idx_d = '0;
            timer_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (state_d == DRIVE || state_d == SAMPLE)
      col_drive_c = ~(4'b0001 << col_idx_d);
  end

  logic [15:0] raw_q;

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= '0;
    end else if (sample_c) begin
      for (int r = 0; r < 4; r++)
        raw_q[{2'(r), col_idx_q}] <= ~row_sync_q[r];
    end
  end

  // Per-key debounce: count consecutive scans disagreeing with the debounced state
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_inc_c;
  logic             differ_c, toggle_c;
  logic             push_c;
  logic [4:0]       push_code_c;

  always_comb begin
    differ_c  = raw_q[key_idx_q] != key_pressed[key_idx_q];
    cnt_inc_c = cnt_q[key_idx_q] + CNT_W'(1);
    toggle_c  = commit_c && differ_c && (cnt_inc_c == CNT_W'(DEBOUNCE_SCANS));
`ifdef KEYPAD_RELEASE_EVENT_EN
    push_c      = toggle_c;
    push_code_c = {key_pressed[key_idx_q], key_idx_q};
`else
    push_c      = toggle_c && !key_pressed[key_idx_q];
    push_code_c = {1'b0, key_idx_q};
`endif
  end

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) cnt_q[k] <= '0;
      key_pressed <= '0;
    end else if (commit_c) begin
      if (!differ_c || toggle_c) cnt_q[key_idx_q] <= '0;
      else                       cnt_q[key_idx_q] <= cnt_inc_c;
      if (toggle_c) key_pressed[key_idx_q] <= ~key_pressed[key_idx_q];
    end
  end

  // FWFT event FIFO with registered head; push while full is accepted only with a pop
  logic [4:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_c, pop_c, wr_en_c, drop_c;
  logic [4:0]       head_d;

  always_comb begin
    full_c   = level_q == LVL_W'(FIFO_DEPTH);
    pop_c    = key_valid && key_ready;
    wr_en_c  = push_c && (!full_c || pop_c);
    drop_c   = push_c && full_c && !pop_c;
    rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(wr_en_c) - LVL_W'(pop_c);
    if (wr_en_c && (level_q - LVL_W'(pop_c)) == '0) head_d = push_code_c;
    else                                            head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem_q[wr_ptr_q] <= push_code_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      key_valid <= level_d != '0;
      key_code  <= head_d;
      if (drop_c)            overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  assign irq = key_valid;

endmodule
